// File: rtl/rr_ring_arbiter.sv
// rtl/rr_ring_arbiter.sv - round-robin ring arbiter holding a one-hot grant until done or req drop
// Forced release after MAX_HOLD cycles is enabled by defining RR_RING_ARBITER_TIMEOUT_EN.
module rr_ring_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  input  logic                 done,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx,
  output logic                 busy,
  output logic                 timeout
);
  localparam int IDX_W = $clog2(N);

  typedef enum logic {IDLE, GRANT} state_e;

  if (!((2 ** CNT_W) > MAX_HOLD) || N < 2 || N > 16) begin : g_bad_cfg
    $error("rr_ring_arbiter: invalid N/MAX_HOLD/CNT_W combination");
  end

  state_e           state_q;
  logic [N-1:0]     ptr_q;
  logic [N-1:0]     grant_q;
  logic [IDX_W-1:0] idx_q;
  logic             busy_q;
  logic             timeout_q;
`ifdef RR_RING_ARBITER_TIMEOUT_EN
  logic [CNT_W-1:0] hold_cnt_q;
`endif

  logic [N-1:0]     req_hi;
  logic [N-1:0]     grant_d;
  logic [IDX_W-1:0] idx_d;
  logic [N-1:0]     ptr_d;
  logic             owner_rel;

  // Bits at or above the pointer win first; otherwise wrap to the lowest set bit.
  always_comb begin
    req_hi = req & ~(ptr_q - N'(1));
    if (|req_hi) grant_d = req_hi & (~req_hi + N'(1));
    else         grant_d = req & (~req + N'(1));
    idx_d = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_d[i]) idx_d = IDX_W'(i);
    end
  end

  assign ptr_d     = {grant_q[N-2:0], grant_q[N-1]};
  assign owner_rel = done | ~(|(req & grant_q));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      ptr_q      <= N'(1);
      grant_q    <= '0;
      idx_q      <= '0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
`ifdef RR_RING_ARBITER_TIMEOUT_EN
      hold_cnt_q <= '0;
`endif
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|req) begin
            grant_q    <= grant_d;
            idx_q      <= idx_d;
            busy_q     <= 1'b1;
            state_q    <= GRANT;
`ifdef RR_RING_ARBITER_TIMEOUT_EN
            hold_cnt_q <= '0;
`endif
          end
        end
        GRANT: begin
`ifdef RR_RING_ARBITER_TIMEOUT_EN
          if (hold_cnt_q != '1) hold_cnt_q <= hold_cnt_q + CNT_W'(1);
`endif
          if (owner_rel) begin
            grant_q <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            ptr_q   <= ptr_d;
            state_q <= IDLE;
          end
`ifdef RR_RING_ARBITER_TIMEOUT_EN
          else if (hold_cnt_q == CNT_W'(MAX_HOLD - 1)) begin
            grant_q   <= '0;
            idx_q     <= '0;
            busy_q    <= 1'b0;
            ptr_q     <= ptr_d;
            timeout_q <= 1'b1;
            state_q   <= IDLE;
          end
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant     = grant_q;
  assign grant_idx = idx_q;
  assign busy      = busy_q;
  assign timeout   = timeout_q;
endmodule

// File: tb/tb_rr_ring_arbiter.sv
// tb/tb_rr_ring_arbiter.sv - self-checking bench for rr_ring_arbiter
// Reference model tracks owner/pointer as integers; directed literal checks pin the model.
module tb_rr_ring_arbiter;
  localparam int N        = 4;
  localparam int MAX_HOLD = 8;
  localparam int CNT_W    = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] req = '0;
  logic         done = 1'b0;
  logic [N-1:0] grant;
  logic [1:0]   grant_idx;
  logic         busy;
  logic         timeout;

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 1'b0;

  rr_ring_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .req(req), .done(done),
    .grant(grant), .grant_idx(grant_idx), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: owner index (-1 idle), priority start index, visible-cycle count.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_hold  = 0;
  bit m_to    = 1'b0;

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_owner <= -1;
      m_ptr   <= 0;
      m_hold  <= 0;
      m_to    <= 1'b0;
    end else begin
      m_to <= 1'b0;
      if (m_owner < 0) begin
        if (req != '0) begin
          m_owner <= pick(req, m_ptr);
          m_hold  <= 1;
        end
      end else if (done || !req[m_owner]) begin
        m_owner <= -1;
        m_ptr   <= (m_owner + 1) % N;
      end
`ifdef RR_RING_ARBITER_TIMEOUT_EN
      else if (m_hold == MAX_HOLD) begin
        m_owner <= -1;
        m_ptr   <= (m_owner + 1) % N;
        m_to    <= 1'b1;
      end
`endif
      else begin
        m_hold <= m_hold + 1;
      end
    end
  end

  always @(negedge clk) begin
    #1;
    if (cmp_en) begin
      chk("m_grant", grant, (m_owner < 0) ? 0 : (1 << m_owner));
      chk("m_grant_idx", grant_idx, (m_owner < 0) ? 0 : m_owner);
      chk("m_busy", busy, (m_owner >= 0) ? 1 : 0);
      chk("m_timeout", timeout, m_to ? 1 : 0);
      chk("grant_onehot", ($countones(grant) <= 1) ? 1 : 0, 1);
    end
  end

  task automatic go(input logic [N-1:0] r, input logic d);
    @(negedge clk);
    req  = r;
    done = d;
  endtask

  task automatic do_reset(input logic [N-1:0] r);
    @(negedge clk);
    reset = 1'b1;
    req   = r;
    done  = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  logic [N-1:0] fair_seq [5];

  initial begin
    fair_seq[0] = 4'b0001; fair_seq[1] = 4'b0010; fair_seq[2] = 4'b0100;
    fair_seq[3] = 4'b1000; fair_seq[4] = 4'b0001;

    // Reset with all requests active
    req = 4'b1111;
    @(negedge clk);
    cmp_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_idx", grant_idx, 0);
    chk("rst_timeout", timeout, 0);
    reset = 1'b0;

    // Fairness: done two cycles after each grant
    for (int i = 0; i < 5; i++) begin
      go(4'b1111, 1'b0); chk("fair_grant", grant, fair_seq[i]);
      go(4'b1111, 1'b1); chk("fair_hold", grant, fair_seq[i]);
      go(4'b1111, 1'b0); chk("fair_idle", grant, 0);
    end

    // Pointer wrap
    do_reset(4'b0100);
    go(4'b0100, 1'b1); chk("wrap_first", grant, 4'b0100);
    go(4'b0101, 1'b0); chk("wrap_idle", grant, 0);
    go(4'b0101, 1'b0); chk("wrap_grant", grant, 4'b0001);
    chk("wrap_idx", grant_idx, 0);

    // Request drop by owner
    do_reset(4'b1010);
    go(4'b1000, 1'b0); chk("drop_first", grant, 4'b0010);
    go(4'b1000, 1'b0); chk("drop_idle", grant, 0);
    go(4'b1000, 1'b0); chk("drop_next", grant, 4'b1000);
    chk("drop_idx", grant_idx, 3);

    // Async reset mid-grant
    do_reset(4'b0100);
    go(4'b0100, 1'b0); chk("areset_pre", grant, 4'b0100);
    #2 reset = 1'b1; req = 4'b1111;
    #1 chk("areset_grant", grant, 0);
    chk("areset_timeout", timeout, 0);
    #1 reset = 1'b0;
    go(4'b1111, 1'b1); chk("areset_after", grant, 4'b0001);
    go(4'b0000, 1'b0);

`ifdef RR_RING_ARBITER_TIMEOUT_EN
    // Forced release after MAX_HOLD visible cycles
    do_reset(4'b0010);
    for (int i = 0; i < MAX_HOLD; i++) begin
      go(4'b0010, 1'b0); chk("to_hold", grant, 4'b0010);
      chk("to_quiet", timeout, 0);
    end
    go(4'b0010, 1'b0); chk("to_release", grant, 0);
    chk("to_pulse", timeout, 1);
    go(4'b0010, 1'b0); chk("to_regrant", grant, 4'b0010);
    chk("to_pulse_end", timeout, 0);
`else
    // Without the timeout the grant is held indefinitely
    do_reset(4'b0010);
    for (int i = 0; i < 3 * MAX_HOLD; i++) begin
      go(4'b0010, 1'b0); chk("hold_forever", grant, 4'b0010);
    end
    chk("hold_no_timeout", timeout, 0);
`endif

    // Randomized traffic checked by the model
    do_reset(4'b0000);
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 99) < 25) req = N'($urandom);
      done = ($urandom_range(0, 99) < 12);
    end
    @(negedge clk);
    reset = 1'b0;
    req   = '0;
    done  = 1'b0;
    repeat (3) @(negedge clk);
    cmp_en = 1'b0;
    #2;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
